lsu_ctrl: RTL and testbench

LSU_CTRL -- requirements
Module: lsu_ctrl

---
 rtl/lsu_ctrl_if.sv | 34 +++
 rtl/lsu_ctrl.sv | 169 ++++++++++++++++
 tb/tb_lsu_ctrl.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/lsu_ctrl_if.sv
// Bundles the CPU request/response handshake and the word-wide memory port
// that lsu_ctrl sits between.  The controller takes the slave view; whoever
// issues requests and models memory takes the master view.
interface lsu_ctrl_if;
  // CPU side
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  memop;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] rdata;
  // Memory side
  logic [31:0] mem_addr;
  logic        mem_ren;
  logic        mem_wen;
  logic [3:0]  mem_ben;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_store, memop, addr, wdata, mem_rdata,
    output req_ready, resp_valid, resp_err, rdata,
           mem_addr, mem_ren, mem_wen, mem_ben, mem_wdata
  );

  modport master (
    output req_valid, req_store, memop, addr, wdata, mem_rdata,
    input  req_ready, resp_valid, resp_err, rdata,
           mem_addr, mem_ren, mem_wen, mem_ben, mem_wdata
  );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: turns one byte/half/word CPU access into one or
// two aligned word accesses, positions store lanes, and reassembles and
// extends load data.  Word-crossing accesses are either split in two or
// rejected, depending on MISALIGN_EN.
module lsu_ctrl #(
  parameter logic MISALIGN_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  lsu_ctrl_if.slave   bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACC1 = 2'd1;
  localparam logic [1:0] ACC2 = 2'd2;
  localparam logic [1:0] FIN  = 2'd3;

  // Byte-lane mask of an access, right-aligned, from memop[1:0].
  function automatic logic [3:0] sizeMask(input logic [1:0] sz);
    case (sz)
      2'b00:   return 4'b0001;
      2'b01:   return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Only the five listed encodings are legal; 011, 110 and 111 are not.
  function automatic logic memopValid(input logic [2:0] op);
    return (op == 3'b000) || (op == 3'b001) || (op == 3'b010) ||
           (op == 3'b100) || (op == 3'b101);
  endfunction

  // An access crosses into the next word when offset + byte count > 4.
  function automatic logic isSplit(input logic [1:0] off, input logic [1:0] sz);
    logic [2:0] bytes;
    case (sz)
      2'b00:   bytes = 3'd1;
      2'b01:   bytes = 3'd2;
      default: bytes = 3'd4;
    endcase
    return ({1'b0, off} + bytes) > 3'd4;
  endfunction

  logic [1:0]  state_q, state_d;
  logic        store_q;
  logic [2:0]  memop_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] lo_q;
  logic        err_q;

  logic        accept;
  logic        reqReject;
  logic        splitQ;
  logic [63:0] storeWide;
  logic [7:0]  benWide;
  logic [31:0] hiWord;
  logic [31:0] loWord;
  logic [31:0] loadWord;
  logic [31:0] loadExt;

  assign accept    = bus.req_valid && (state_q == IDLE);
  assign reqReject = !memopValid(bus.memop) ||
                     (isSplit(bus.addr[1:0], bus.memop[1:0]) && !MISALIGN_EN);
  assign splitQ    = isSplit(addr_q[1:0], memop_q[1:0]);

  // Store data and lane enables laid out over the two words touched.
  assign storeWide = {32'b0, wdata_q} << {addr_q[1:0], 3'b000};
  assign benWide   = {4'b0, sizeMask(memop_q[1:0])} << addr_q[1:0];

  // Load reassembly: an aligned access uses only the current read word.
  assign hiWord   = splitQ ? bus.mem_rdata : 32'b0;
  assign loWord   = splitQ ? lo_q : bus.mem_rdata;
  assign loadWord = 32'({hiWord, loWord} >> {addr_q[1:0], 3'b000});

  // Truncate the reassembled word to the access size and extend it.
  always_comb begin
    loadExt = 32'b0;
    case (memop_q)
      3'b000:  loadExt = {{24{loadWord[7]}}, loadWord[7:0]};
      3'b001:  loadExt = {{16{loadWord[15]}}, loadWord[15:0]};
      3'b010:  loadExt = loadWord;
      3'b100:  loadExt = {24'b0, loadWord[7:0]};
      3'b101:  loadExt = {16'b0, loadWord[15:0]};
      default: loadExt = 32'b0;
    endcase
  end

  // Sequencing: rejected requests go straight to FIN without touching memory.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.req_valid) state_d = reqReject ? FIN : ACC1;
      ACC1: state_d = splitQ ? ACC2 : FIN;
      ACC2: state_d = FIN;
      FIN:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and request capture; the low word of a split load is held in ACC2.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      store_q <= 1'b0;
      memop_q <= 3'b0;
      addr_q  <= 32'b0;
      wdata_q <= 32'b0;
      lo_q    <= 32'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        store_q <= bus.req_store;
        memop_q <= bus.memop;
        addr_q  <= bus.addr;
        wdata_q <= bus.wdata;
        err_q   <= reqReject;
      end
      if (state_q == ACC2) begin
        lo_q <= bus.mem_rdata;
      end
    end
  end

  // Outputs decode from state; while reset is held everything is quiet.
  always_comb begin
    bus.req_ready  = !rst_n || (state_q == IDLE);
    bus.resp_valid = 1'b0;
    bus.resp_err   = 1'b0;
    bus.rdata      = 32'b0;
    bus.mem_addr   = 32'b0;
    bus.mem_ren    = 1'b0;
    bus.mem_wen    = 1'b0;
    bus.mem_ben    = 4'b0;
    bus.mem_wdata  = 32'b0;
    if (rst_n) begin
      case (state_q)
        ACC1: begin
          bus.mem_addr = {addr_q[31:2], 2'b00};
          if (store_q) begin
            bus.mem_wen   = 1'b1;
            bus.mem_ben   = benWide[3:0];
            bus.mem_wdata = storeWide[31:0];
          end else begin
            bus.mem_ren = 1'b1;
          end
        end
        ACC2: begin
          bus.mem_addr = {addr_q[31:2], 2'b00} + 32'd4;
          if (store_q) begin
            bus.mem_wen   = 1'b1;
            bus.mem_ben   = benWide[7:4];
            bus.mem_wdata = storeWide[63:32];
          end else begin
            bus.mem_ren = 1'b1;
          end
        end
        FIN: begin
          bus.resp_valid = 1'b1;
          bus.resp_err   = err_q;
          bus.rdata      = (err_q || store_q) ? 32'b0 : loadExt;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: one instance with splitting enabled backed by
// a small word memory, one with splitting disabled that must never touch
// memory.  Inputs change and outputs are sampled on the falling clock edge.
module tb_lsu_ctrl;

  typedef struct {
    string       name;
    logic        onB;
    logic        store;
    logic [2:0]  memop;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          expLat;
    logic        expErr;
    logic [31:0] expRdata;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic loadMem;
  int   checks = 0;
  int   failures = 0;
  int   violA = 0;
  int   accB = 0;

  logic [31:0] memA [0:255];

  lsu_ctrl_if busA();
  lsu_ctrl_if busB();

  lsu_ctrl #(.MISALIGN_EN(1'b1)) dutA (.clk(clk), .rst_n(rst_n), .bus(busA.slave));
  lsu_ctrl #(.MISALIGN_EN(1'b0)) dutB (.clk(clk), .rst_n(rst_n), .bus(busB.slave));

  always #5 clk = ~clk;

  // Word memory for instance A: reads return one cycle later, writes per lane.
  always @(posedge clk) begin
    if (loadMem) begin
      memA[64] <= 32'h44332211;
      memA[65] <= 32'h88776655;
    end
    if (busA.mem_ren) busA.mem_rdata <= memA[busA.mem_addr[9:2]];
    if (busA.mem_wen) begin
      for (int i = 0; i < 4; i++)
        if (busA.mem_ben[i]) memA[busA.mem_addr[9:2]][8*i +: 8] <= busA.mem_wdata[8*i +: 8];
    end
  end

  // Continuous protocol watch; the totals are compared at the end.
  always @(negedge clk) begin
    if (busA.mem_ren && busA.mem_wen) violA <= violA + 1;
    if (!busA.mem_wen && (busA.mem_ben != 4'b0 || busA.mem_wdata != 32'b0)) violA <= violA + 1;
    if (!busA.resp_valid && (busA.resp_err || busA.rdata != 32'b0)) violA <= violA + 1;
    if (busA.mem_addr[1:0] != 2'b00) violA <= violA + 1;
    if (busB.mem_ren || busB.mem_wen) accB <= accB + 1;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  // Presents one request and returns at the falling edge of cycle T+1.
  task automatic applyStimulus(input logic onB, input logic store, input logic [2:0] memop,
                               input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    if (onB) begin
      busB.req_valid = 1'b1; busB.req_store = store; busB.memop = memop;
      busB.addr = addr; busB.wdata = wdata;
      checkOutput("readyB", {31'b0, busB.req_ready}, 32'd1);
    end else begin
      busA.req_valid = 1'b1; busA.req_store = store; busA.memop = memop;
      busA.addr = addr; busA.wdata = wdata;
      checkOutput("readyA", {31'b0, busA.req_ready}, 32'd1);
    end
    @(posedge clk);
    @(negedge clk);
    busA.req_valid = 1'b0;
    busB.req_valid = 1'b0;
  endtask

  // Waits (bounded) for the response; lat = cycles after the accept edge.
  task automatic waitResp(input logic onB, output int lat, output logic err, output logic [31:0] rd);
    lat = 0; err = 1'b0; rd = 32'b0;
    for (int k = 1; k <= 6; k++) begin
      if (onB ? busB.resp_valid : busA.resp_valid) begin
        lat = k;
        err = onB ? busB.resp_err : busA.resp_err;
        rd  = onB ? busB.rdata : busA.rdata;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic runVec(input vec_t v);
    int lat; logic err; logic [31:0] rd;
    applyStimulus(v.onB, v.store, v.memop, v.addr, v.wdata);
    waitResp(v.onB, lat, err, rd);
    checkOutput({v.name, " latency"}, lat, v.expLat);
    checkOutput({v.name, " err"}, {31'b0, err}, {31'b0, v.expErr});
    checkOutput({v.name, " rdata"}, rd, v.expRdata);
  endtask

  task automatic checkMemA(input string name, input logic ren, input logic wen,
                           input logic [31:0] ad, input logic [3:0] ben, input logic [31:0] wd);
    checkOutput({name, " ren"}, {31'b0, busA.mem_ren}, {31'b0, ren});
    checkOutput({name, " wen"}, {31'b0, busA.mem_wen}, {31'b0, wen});
    checkOutput({name, " addr"}, busA.mem_addr, ad);
    checkOutput({name, " ben"}, {28'b0, busA.mem_ben}, {28'b0, ben});
    checkOutput({name, " wdata"}, busA.mem_wdata, wd);
  endtask

  vec_t loads[$];
  vec_t after[$];
  int   quietCount;

  initial begin
    loads = '{
      '{"lb 103",   1'b0, 1'b0, 3'b000, 32'h103, 32'h0, 2, 1'b0, 32'h00000044},
      '{"lb 107",   1'b0, 1'b0, 3'b000, 32'h107, 32'h0, 2, 1'b0, 32'hFFFFFF88},
      '{"lbu 107",  1'b0, 1'b0, 3'b100, 32'h107, 32'h0, 2, 1'b0, 32'h00000088},
      '{"lw 102",   1'b0, 1'b0, 3'b010, 32'h102, 32'h0, 3, 1'b0, 32'h66554433},
      '{"lh 106",   1'b0, 1'b0, 3'b001, 32'h106, 32'h0, 2, 1'b0, 32'hFFFF8877},
      '{"lhu 106",  1'b0, 1'b0, 3'b101, 32'h106, 32'h0, 2, 1'b0, 32'h00008877},
      '{"lh 103",   1'b0, 1'b0, 3'b001, 32'h103, 32'h0, 3, 1'b0, 32'h00005544},
      '{"lw 100",   1'b0, 1'b0, 3'b010, 32'h100, 32'h0, 2, 1'b0, 32'h44332211},
      '{"op011 A",  1'b0, 1'b0, 3'b011, 32'h100, 32'h0, 1, 1'b1, 32'h0},
      '{"B lw 101", 1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 1, 1'b1, 32'h0},
      '{"B op011",  1'b1, 1'b0, 3'b011, 32'h100, 32'h0, 1, 1'b1, 32'h0},
      '{"B sh 103", 1'b1, 1'b1, 3'b001, 32'h103, 32'hBEEF, 1, 1'b1, 32'h0}
    };

    busA.req_valid = 1'b0; busA.req_store = 1'b0; busA.memop = 3'b0;
    busA.addr = 32'b0; busA.wdata = 32'b0;
    busB.req_valid = 1'b0; busB.req_store = 1'b0; busB.memop = 3'b0;
    busB.addr = 32'b0; busB.wdata = 32'b0; busB.mem_rdata = 32'b0;
    rst_n = 1'b0;
    loadMem = 1'b1;

    // Reset state, sampled while reset is still held.
    repeat (2) @(posedge clk);
    @(negedge clk);
    loadMem = 1'b0;
    checkOutput("rst ready", {31'b0, busA.req_ready}, 32'd1);
    checkOutput("rst resp_valid", {31'b0, busA.resp_valid}, 32'd0);
    checkOutput("rst resp_err", {31'b0, busA.resp_err}, 32'd0);
    checkOutput("rst rdata", busA.rdata, 32'd0);
    checkMemA("rst", 1'b0, 1'b0, 32'h0, 4'b0, 32'h0);
    rst_n = 1'b1;

    foreach (loads[i]) runVec(loads[i]);

    // Split load: two word reads at consecutive addresses.
    applyStimulus(1'b0, 1'b0, 3'b010, 32'h102, 32'h0);
    checkMemA("lw102 T+1", 1'b1, 1'b0, 32'h100, 4'b0, 32'h0);
    @(negedge clk);
    checkMemA("lw102 T+2", 1'b1, 1'b0, 32'h104, 4'b0, 32'h0);
    @(negedge clk);
    checkOutput("lw102 T+3 resp", {31'b0, busA.resp_valid}, 32'd1);

    // Split halfword store: lane placement across both words.
    applyStimulus(1'b0, 1'b1, 3'b001, 32'h103, 32'h0000BEEF);
    checkMemA("sh103 T+1", 1'b0, 1'b1, 32'h100, 4'b1000, 32'hEF000000);
    @(negedge clk);
    checkMemA("sh103 T+2", 1'b0, 1'b1, 32'h104, 4'b0001, 32'h000000BE);
    @(negedge clk);
    checkOutput("sh103 T+3 resp", {31'b0, busA.resp_valid}, 32'd1);
    checkOutput("sh103 rdata", busA.rdata, 32'd0);

    // Aligned word store: a single full-lane write, response at T+2.
    applyStimulus(1'b0, 1'b1, 3'b010, 32'h100, 32'hCAFEF00D);
    checkMemA("sw100 T+1", 1'b0, 1'b1, 32'h100, 4'b1111, 32'hCAFEF00D);
    @(negedge clk);
    checkOutput("sw100 T+2 resp", {31'b0, busA.resp_valid}, 32'd1);
    checkOutput("sw100 T+2 wen", {31'b0, busA.mem_wen}, 32'd0);

    after = '{
      '{"lw 100 post", 1'b0, 1'b0, 3'b010, 32'h100, 32'h0, 2, 1'b0, 32'hCAFEF00D},
      '{"lw 104 post", 1'b0, 1'b0, 3'b010, 32'h104, 32'h0, 2, 1'b0, 32'h887766BE},
      '{"lb 103 post", 1'b0, 1'b0, 3'b000, 32'h103, 32'h0, 2, 1'b0, 32'hFFFFFFCA}
    };
    foreach (after[i]) runVec(after[i]);

    // Reset during the second half of a split store.
    applyStimulus(1'b0, 1'b1, 3'b010, 32'h101, 32'h11223344);
    checkMemA("sw101 T+1", 1'b0, 1'b1, 32'h100, 4'b1110, 32'h22334400);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    checkMemA("sw101 rst T+2", 1'b0, 1'b0, 32'h0, 4'b0, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post-rst ready", {31'b0, busA.req_ready}, 32'd1);
    quietCount = 0;
    for (int k = 0; k < 4; k++) begin
      if (busA.resp_valid) quietCount++;
      @(negedge clk);
    end
    checkOutput("post-rst no resp", quietCount, 32'd0);
    runVec('{"lw 104 after rst", 1'b0, 1'b0, 3'b010, 32'h104, 32'h0, 2, 1'b0, 32'h887766BE});
    runVec('{"lw 100 after rst", 1'b0, 1'b0, 3'b010, 32'h100, 32'h0, 2, 1'b0, 32'h2233440D});

    @(negedge clk);
    checkOutput("A protocol violations", violA, 32'd0);
    checkOutput("B memory accesses", accB, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
